// File: rtl/clk_gen_pkg.sv
// Shared constants and types for the clk_gen behavioural clock source.
`timescale 1ns/1ps
package clk_gen_pkg;

    localparam int CLK_GEN_DEFAULT_PERIOD = 2;
    localparam int CLK_GEN_DEFAULT_CNT_W  = 32;

    typedef logic [CLK_GEN_DEFAULT_CNT_W-1:0] cycle_cnt_t;

endpackage

// File: rtl/clk_gen_if.sv
// Bundle of clk_gen run control and observed outputs; master drives rst, slave is the generator.
`timescale 1ns/1ps
interface clk_gen_if
    import clk_gen_pkg::*;
#(
    parameter int CNT_W = CLK_GEN_DEFAULT_CNT_W
);

    logic             rst;
    logic             clk;
    logic             running;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (output rst, input clk, input running, input cycle_cnt);
    modport slave  (input rst, output clk, output running, output cycle_cnt);

endinterface

// File: rtl/clk_gen_counter.sv
// Rising-edge counter of the generated clock, cleared asynchronously while rst is low.
`timescale 1ns/1ps
module clk_gen_counter
    import clk_gen_pkg::*;
#(
    parameter int CNT_W = CLK_GEN_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cycle_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Natural wrap modulo 2^CNT_W
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cycle_cnt = cnt_q;
    end

endmodule

// File: rtl/clk_gen.sv
// Behavioural free-running clock source with run flag and optional edge counter.
// Optional counter enabled by defining CLK_GEN_COUNTER_EN.
`timescale 1ns/1ps
module clk_gen
    import clk_gen_pkg::*;
#(
    parameter int CLK_PERIOD = CLK_GEN_DEFAULT_PERIOD,
    parameter int CNT_W      = CLK_GEN_DEFAULT_CNT_W
) (
    input  logic             rst,
    output logic             clk,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int T_HIGH = CLK_PERIOD / 2;
    localparam int T_LOW  = CLK_PERIOD - T_HIGH;

    logic        clk_q;
    logic        running_q;
    logic        rst_ok;
    int unsigned epoch_q;

    // X/Z on rst counts as asserted
    always_comb begin
        rst_ok = (rst === 1'b1);
    end

    // Each release starts a new epoch; an edge loop from an older epoch
    // exits at its next wake-up without touching the outputs.
    task automatic run_edges(input int unsigned epoch);
        forever begin
            #(T_LOW);
            if (epoch != epoch_q || rst !== 1'b1) return;
            clk_q     = 1'b1;
            running_q = 1'b1;
            #(T_HIGH);
            if (epoch != epoch_q || rst !== 1'b1) return;
            clk_q = 1'b0;
        end
    endtask

    initial begin
        if (CLK_PERIOD < 2) $fatal(1, "clk_gen: CLK_PERIOD=%0d must be >= 2", CLK_PERIOD);
        if (CNT_W < 1 || CNT_W > 64) $fatal(1, "clk_gen: CNT_W=%0d must be in 1..64", CNT_W);
        epoch_q   = 0;
        clk_q     = 1'b0;
        running_q = 1'b0;
        forever begin
            wait (rst === 1'b1);
            epoch_q = epoch_q + 1;
            fork
                run_edges(epoch_q);
            join_none
            wait (rst !== 1'b1);
            epoch_q   = epoch_q + 1;
            clk_q     = 1'b0;
            running_q = 1'b0;
        end
    end

    always_comb begin
        clk     = clk_q;
        running = running_q;
    end

`ifdef CLK_GEN_COUNTER_EN
    logic [CNT_W-1:0] cnt;

    clk_gen_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk       (clk_q),
        .rst       (rst_ok),
        .cycle_cnt (cnt)
    );

    // Gate keeps the output at zero from time 0 even before the counter sees a reset edge
    always_comb begin
        cycle_cnt = rst_ok ? cnt : '0;
    end
`else
    always_comb begin
        cycle_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_clk_gen.sv
// Directed bench for clk_gen: phase timing, reset cancellation, short pulses, wrap.
`timescale 1ns/1ps
module tb_clk_gen;

    clk_gen_if #(.CNT_W(32)) ia ();
    clk_gen_if #(.CNT_W(32)) ib ();
    clk_gen_if #(.CNT_W(4))  ic ();

    clk_gen #(.CLK_PERIOD(2), .CNT_W(32)) u_dut_a (
        .rst (ia.rst), .clk (ia.clk), .running (ia.running), .cycle_cnt (ia.cycle_cnt)
    );
    clk_gen #(.CLK_PERIOD(5), .CNT_W(32)) u_dut_b (
        .rst (ib.rst), .clk (ib.clk), .running (ib.running), .cycle_cnt (ib.cycle_cnt)
    );
    clk_gen #(.CLK_PERIOD(2), .CNT_W(4)) u_dut_c (
        .rst (ic.rst), .clk (ic.clk), .running (ic.running), .cycle_cnt (ic.cycle_cnt)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $realtime, got, exp);
        end
    endtask

    // Expected count: the counter only exists when the macro is defined
    function automatic logic [63:0] ec(input int unsigned n);
`ifdef CLK_GEN_COUNTER_EN
        return 64'(n);
`else
        return 64'(n & 0);
`endif
    endfunction

    task automatic at(input realtime t);
        #(t - $realtime);
    endtask

    task automatic chk3(input string tag, input clk_e, input run_e, input logic [63:0] cnt_e,
                        input logic c, input logic r, input logic [63:0] n);
        chk({tag, ".clk"}, 64'(c), 64'(clk_e));
        chk({tag, ".run"}, 64'(r), 64'(run_e));
        chk({tag, ".cnt"}, n, cnt_e);
    endtask

    task automatic seq_a();
        ia.rst = 1'b0;
        at(2.5);  chk3("a_rst",    0, 0, 0,     ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(5.0);  ia.rst = 1'b1;
        at(5.5);  chk3("a_low0",   0, 0, 0,     ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(6.5);  chk3("a_rise6",  1, 1, ec(1), ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(7.5);  chk("a_fall7", 64'(ia.clk), 0);
        at(8.5);  chk3("a_rise8",  1, 1, ec(2), ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(9.5);  chk("a_fall9", 64'(ia.clk), 0);
        at(10.5); chk3("a_rise10", 1, 1, ec(3), ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(11.0); ia.rst = 1'b0;
        at(11.2); chk3("a_midrst", 0, 0, 0,     ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(14.0); ia.rst = 1'b1;
        at(14.5); chk3("a_nostale",0, 0, 0,     ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(15.5); chk3("a_rel15",  1, 1, ec(1), ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(19.5); chk3("a_rise19", 1, 1, ec(3), ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(20.0); ia.rst = 1'b0;
        at(20.2); chk3("a_pulse",  0, 0, 0,     ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(20.5); ia.rst = 1'b1;
        at(21.2); chk3("a_no_old21", 0, 0, 0,   ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(21.7); chk3("a_rise21p5", 1, 1, ec(1), ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(22.7); chk("a_fall22p5", 64'(ia.clk), 0);
        at(23.7); chk3("a_rise23p5", 1, 1, ec(2), ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(25.5); ia.rst = 1'b0;
        at(25.7); chk3("a_simul",  0, 0, 0,     ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(26.0); ia.rst = 1'b1;
        at(27.2); chk3("a_rel26",  1, 1, ec(1), ia.clk, ia.running, 64'(ia.cycle_cnt));
        at(28.0); ia.rst = 1'bx;
        at(28.2); chk3("a_rstx",   0, 0, 0,     ia.clk, ia.running, 64'(ia.cycle_cnt));
    endtask

    task automatic seq_b();
        ib.rst = 1'b1;
        at(2.9);  chk3("b_low0",   0, 0, 0,     ib.clk, ib.running, 64'(ib.cycle_cnt));
        at(3.1);  chk3("b_rise3",  1, 1, ec(1), ib.clk, ib.running, 64'(ib.cycle_cnt));
        at(4.9);  chk("b_high4p9", 64'(ib.clk), 1);
        at(5.1);  chk("b_fall5",   64'(ib.clk), 0);
        at(7.9);  chk("b_low7p9",  64'(ib.clk), 0);
        at(8.1);  chk3("b_rise8",  1, 1, ec(2), ib.clk, ib.running, 64'(ib.cycle_cnt));
        at(10.1); chk("b_fall10",  64'(ib.clk), 0);
        at(13.1); chk3("b_rise13", 1, 1, ec(3), ib.clk, ib.running, 64'(ib.cycle_cnt));
    endtask

    task automatic seq_c();
        ic.rst = 1'b0;
        at(1.0);  ic.rst = 1'b1;
        at(30.5); chk3("c_cnt15",  1, 1, ec(15), ic.clk, ic.running, 64'(ic.cycle_cnt));
        at(31.5); chk3("c_hold15", 0, 1, ec(15), ic.clk, ic.running, 64'(ic.cycle_cnt));
        at(32.5); chk3("c_wrap",   1, 1, 0,      ic.clk, ic.running, 64'(ic.cycle_cnt));
        at(34.5); chk3("c_after",  1, 1, ec(1),  ic.clk, ic.running, 64'(ic.cycle_cnt));
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
            seq_c();
        join
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_gen.md
CLK_GEN -- requirements
Module: clk_gen

Interface
REQ-001 Parameter CLK_PERIOD, default 2, clock period in ns; integer >= 2.
REQ-002 Parameter CNT_W, default 32, width of cycle_cnt; integer 1..64.
REQ-003 Reset rst is asynchronous and active-low; the clock is clk.
REQ-004 Port: rst  input  1  asynchronous active-low run enable/reset.
REQ-005 Port: clk  output  1  generated clock, free-running while rst high.
REQ-006 Port: running  output  1  high from the first clk rising edge after reset release.
REQ-007 Port: cycle_cnt  output  CNT_W  count of clk rising edges since last reset release.
REQ-008 Module compiles under timescale 1ns/1ps; all delays are in ns.

Function
REQ-009 Phase times: high = floor(CLK_PERIOD/2) ns; low = CLK_PERIOD - high ns; each period starts with its low phase.
REQ-010 On rst rising at time T: first clk rising edge at T + low. Edges then alternate at high/low intervals indefinitely.
REQ-011 running rises in the same timestep as the first rising edge after release. It stays high until the next reset.
REQ-012 cycle_cnt increments by 1 in the timestep of each clk rising edge, so the first edge yields 1.
REQ-013 cycle_cnt wraps modulo 2^CNT_W: after all-ones, the next edge yields 0. running is unaffected by the wrap.
REQ-014 Reset mid-operation: on rst falling, in the same timestep clk=0, running=0, cycle_cnt=0. A truncated high phase is permitted.
REQ-015 All pending scheduled edges are cancelled on rst falling; a stale edge never appears after re-release.
REQ-016 Simultaneous rst falling and a scheduled edge in the same timestep: reset wins, clk=0, no count.
REQ-017 A reset pulse of any width, including less than CLK_PERIOD, is honoured. Timing restarts from the release instant.
REQ-018 rst X/Z is treated as asserted.
REQ-019 clk never goes X/Z after time 0.
REQ-020 CLK_PERIOD < 2 or CNT_W out of range: $fatal at time 0 with a message naming the parameter.

Reset
REQ-021 While rst is low: clk=0, running=0, cycle_cnt=0.
REQ-022 At time 0 with rst low or unknown, the outputs hold the REQ-021 values from time 0.

Configuration
REQ-023 Macro CLK_GEN_COUNTER_EN defined: cycle_cnt is counted per REQ-012/013.
REQ-024 Macro CLK_GEN_COUNTER_EN undefined: cycle_cnt is tied to 0 and no counter logic exists. clk and running are unchanged.

Structure
REQ-025 Package clk_gen_pkg holds: constant CLK_GEN_DEFAULT_PERIOD=2, constant CLK_GEN_DEFAULT_CNT_W=32, and a typedef for the cycle-count type.
REQ-026 One sub-module, clk_gen_counter, contains the counter. Inputs: clk, rst. Output: cycle_cnt.
REQ-027 clk_gen_counter is instantiated only under CLK_GEN_COUNTER_EN.
REQ-028 The oscillator and running flag live in clk_gen.

Verification
REQ-029 CLK_PERIOD=2, rst low 0–5 ns, high at 5 -> clk rises at 6, 8, 10 and falls at 7, 9. running=1 from 6; cycle_cnt=3 at 10.
REQ-030 Same setup, rst falls at 9 (clk high since 8) -> clk=0, running=0, cycle_cnt=0 at 9. Release at 12 -> next rise at 13, cycle_cnt=1.
REQ-031 CLK_PERIOD=5, release at 0 -> rises at 3, 8, 13. Each high lasts 2 ns, each low 3 ns.
REQ-032 CNT_W=4, CLK_PERIOD=2 -> cycle_cnt=15 after 15 edges; the 16th edge yields 0 while running stays 1.
REQ-033 Reset pulse 0.5 ns wide at 20.0 (CLK_PERIOD=2, running) -> outputs clear at 20.0. First rise at 21.5, with no edge at the old schedule.
REQ-034 CLK_GEN_COUNTER_EN undefined -> cycle_cnt=0 throughout REQ-029 while clk and running match. CLK_PERIOD=1 -> $fatal at time 0.
